// File: rtl/rx_unit_if.sv
// Receiver-side bus: oversample strobe and serial line in, received word and status out.
interface rx_unit_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 serial_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 is_busy;

    // master drives the line and the strobe; slave is the receiver
    modport master (
        output tick, serial_in,
        input  data_out, data_valid, frame_err, is_busy
    );
    modport slave (
        input  tick, serial_in,
        output data_out, data_valid, frame_err, is_busy
    );
endinterface

// File: rtl/rx_unit.sv
// UART receiver: oversampled start-bit validation, LSB-first shift-in,
// stop-bit check, one-cycle valid / frame-error pulses, break hold-off.
module rx_unit #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clock,
    input  logic       rst,
    rx_unit_if.slave   bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               state, state_nx;
    logic                 sync1, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_pos;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q;

    // two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clock) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.serial_in;
            rx_s  <= sync1;
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: IDLE and BRK react to the line alone, the rest wait for ticks
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!rx_s) state_nx = START;
            START: if (bus.tick && tick_cnt == HALF_M1) state_nx = rx_s ? IDLE : DATA;
            DATA:  if (bus.tick && tick_cnt == LAST && bit_pos == LAST_BIT) state_nx = STOP;
            STOP:  if (bus.tick && tick_cnt == LAST) state_nx = rx_s ? IDLE : BRK;
            BRK:   if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // counters, shifter and registered result pulses
    always_ff @(posedge clock) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_pos  <= '0;
            shift    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: tick_cnt <= '0;
                START: if (bus.tick) begin
                    if (tick_cnt == HALF_M1) begin
                        tick_cnt <= '0;
                        bit_pos  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: if (bus.tick) begin
                    if (tick_cnt == LAST) begin
                        shift    <= {rx_s, shift[DATA_BITS-1:1]};
                        tick_cnt <= '0;
                        bit_pos  <= (bit_pos == LAST_BIT) ? '0 : bit_pos + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: if (bus.tick) begin
                    if (tick_cnt == LAST) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs: busy whenever a frame (or a break) is in progress
    always_comb begin
        bus.is_busy    = (state != IDLE);
        bus.data_out   = data_q;
        bus.data_valid = valid_q;
        bus.frame_err  = ferr_q;
    end
endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit with a procedural receiver model checked every cycle.
module tb_rx_unit;
    localparam int OS = 16;
    localparam int DB = 8;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    rx_unit_if #(.DATA_BITS(DB)) bus();
    rx_unit #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (.clock(clock), .rst(rst), .bus(bus));

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    // model outputs and private state
    logic [DB-1:0] exp_data  = '0;
    bit            exp_valid = 1'b0;
    bit            exp_ferr  = 1'b0;
    bit            exp_busy  = 1'b0;
    bit            m_s1 = 1'b1, m_s2 = 1'b1, m_abort = 1'b0;

    // observation
    bit            chk_en = 1'b0;
    int            cyc = 0, dv_cnt = 0, fe_cnt = 0, dv_run = 0, dv_maxrun = 0;
    bit            busy_seen = 1'b0;
    int            dv_cyc[$];
    logic [DB-1:0] dv_dat[$];

    // stimulus tick generator state
    int tick_div = 1, div_cnt = 0;

    // ---------------- model ----------------
    // One clock edge as seen by the receiver: the line value it acts on is the
    // serial input from two edges earlier.
    task automatic step(output bit tk, output bit rx);
        @(posedge clock);
        tk = bus.tick;
        rx = m_s2;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            exp_data = '0; exp_busy = 1'b0;
            m_abort = 1'b1;
        end else begin
            m_s2 = m_s1;
            m_s1 = bus.serial_in;
        end
    endtask

    // Let n ticks go by; return the line value seen on the nth.
    task automatic sample_after(input int n, output bit rx);
        bit tk;
        int c = 0;
        rx = 1'b1;
        while (c < n && !m_abort) begin
            step(tk, rx);
            if (tk && !m_abort) c++;
        end
    endtask

    initial begin : model
        bit tk, rx;
        logic [DB-1:0] w;
        w = '0;
        forever begin
            m_abort  = 1'b0;
            exp_busy = 1'b0;
            forever begin
                step(tk, rx);
                if (m_abort) m_abort = 1'b0;
                else if (!rx) break;
            end
            exp_busy = 1'b1;
            sample_after(OS/2, rx);
            if (m_abort || rx) continue;
            for (int i = 0; i < DB; i++) begin
                sample_after(OS, rx);
                if (m_abort) break;
                w[i] = rx;
            end
            if (m_abort) continue;
            sample_after(OS, rx);
            if (m_abort) continue;
            if (rx) begin
                exp_data  = w;
                exp_valid = 1'b1;
            end else begin
                exp_ferr = 1'b1;
                do step(tk, rx); while (!rx && !m_abort);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            cyc++;
            n_vec++;
            if (bus.data_out !== exp_data || bus.data_valid !== exp_valid ||
                bus.frame_err !== exp_ferr || bus.is_busy !== exp_busy) begin
                n_miss++;
                $display("FAIL cycle %0d: dut data=%0h v=%0b fe=%0b busy=%0b, model data=%0h v=%0b fe=%0b busy=%0b",
                         cyc, bus.data_out, bus.data_valid, bus.frame_err, bus.is_busy,
                         exp_data, exp_valid, exp_ferr, exp_busy);
            end
            if (bus.data_valid === 1'b1) begin
                dv_cnt++;
                dv_cyc.push_back(cyc);
                dv_dat.push_back(bus.data_out);
                dv_run++;
                if (dv_run > dv_maxrun) dv_maxrun = dv_run;
            end else begin
                dv_run = 0;
            end
            if (bus.frame_err === 1'b1) fe_cnt++;
            if (bus.is_busy === 1'b1) busy_seen = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tstep();
        @(negedge clock);
        bus.tick = (div_cnt == 0);
        div_cnt  = (div_cnt + 1) % tick_div;
    endtask

    task automatic hold(input bit v, input int n);
        int c = 0;
        bus.serial_in = v;
        while (c < n) begin
            tstep();
            if (bus.tick) c++;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_v);
        hold(1'b0, OS);
        for (int i = 0; i < DB; i++) hold(b[i], OS);
        hold(stop_v, OS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0, f0;
        bus.tick      = 1'b0;
        bus.serial_in = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        check("reset data_out", bus.data_out, 32'h0);
        check("reset is_busy",  bus.is_busy,  32'h0);
        rst = 1'b0;
        hold(1'b1, 10);

        // 1: single good frame
        send(8'hA5, 1'b1);
        hold(1'b1, 20);
        check("t1 dv count", dv_cnt, 32'd1);
        check("t1 fe count", fe_cnt, 32'd0);
        check("t1 data_out", bus.data_out, 32'hA5);
        check("t1 busy low", bus.is_busy, 32'h0);

        // 2: short low glitch rejected
        busy_seen = 1'b0;
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("t2 busy pulsed", busy_seen, 32'd1);
        check("t2 dv count", dv_cnt, 32'd1);
        check("t2 fe count", fe_cnt, 32'd0);
        check("t2 busy low", bus.is_busy, 32'h0);
        send(8'h3C, 1'b1);
        hold(1'b1, 20);
        check("t2 data_out", bus.data_out, 32'h3C);

        // 3: framing error with held-low break
        send(8'hA5, 1'b1);
        hold(1'b1, 20);
        f0 = fe_cnt;
        send(8'h3C, 1'b0);
        hold(1'b0, 40);
        check("t3 fe pulse", fe_cnt - f0, 32'd1);
        check("t3 data kept", bus.data_out, 32'hA5);
        check("t3 busy in break", bus.is_busy, 32'h1);
        hold(1'b1, 20);
        check("t3 busy after break", bus.is_busy, 32'h0);
        send(8'h5A, 1'b1);
        hold(1'b1, 20);
        check("t3 data_out", bus.data_out, 32'h5A);

        // 4: back-to-back frames
        d0 = dv_cnt;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 20);
        check("t4 dv count", dv_cnt - d0, 32'd2);
        check("t4 spacing", dv_cyc[$] - dv_cyc[$-1], 32'd160);
        check("t4 first word", dv_dat[$-1], 32'h00);
        check("t4 second word", dv_dat[$], 32'hFF);

        // 5: reset mid-frame
        d0 = dv_cnt;
        hold(1'b0, OS);
        hold(1'b1, OS);
        hold(1'b0, OS);
        hold(1'b0, OS);
        bus.serial_in = 1'b1;
        bus.tick      = 1'b0;
        rst           = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("t5 data_out zero", bus.data_out, 32'h0);
        check("t5 busy zero", bus.is_busy, 32'h0);
        check("t5 dv zero", bus.data_valid, 32'h0);
        check("t5 fe zero", bus.frame_err, 32'h0);
        hold(1'b1, 20);
        check("t5 no pulse", dv_cnt - d0, 32'd0);
        send(8'h81, 1'b1);
        hold(1'b1, 20);
        check("t5 data_out", bus.data_out, 32'h81);

        // 6: slow tick, pulse still one clock wide
        tick_div  = 4;
        div_cnt   = 0;
        dv_maxrun = 0;
        d0 = dv_cnt;
        send(8'h96, 1'b1);
        hold(1'b1, 20);
        check("t6 data_out", bus.data_out, 32'h96);
        check("t6 dv count", dv_cnt - d0, 32'd1);
        check("t6 dv width", dv_maxrun, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
